// File: rtl/breakout_pkg.sv
// breakout_pkg: screen geometry, paddle constants and move-state encoding shared by the breakout blocks
package breakout_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_W = 100;
  localparam int PADDLE_START = 270;
  localparam int PADDLE_Y_TOP = 439;
  localparam int PADDLE_Y_BOT = 450;
  localparam int STEP = 4;
  localparam int TICK_DIV = 416667;
  localparam int DEBOUNCE_CYCLES = 250000;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_LEFT = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stable-count debouncer for one raw button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1_q, sync2_q, level_q, level_d, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // accept a change only after the synced level has disagreed for DEBOUNCE_CYCLES clocks
  always_comb begin
    diff = sync2_q != level_q;
    done = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (!diff || done) ? '0 : cnt_q + CW'(1);
    level_d = done ? ~level_q : level_q;
  end
  // synchroniser, counter and debounced level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  assign level_o = level_q;
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced buttons drive a tick-stepped, edge-clamped paddle_x (PADDLE_ACCEL_EN doubles the step on long runs)
module paddle_ctrl import breakout_pkg::*; #(
  parameter int SCREEN_W = breakout_pkg::SCREEN_W,
  parameter int PADDLE_W = breakout_pkg::PADDLE_W,
  parameter int PADDLE_START = breakout_pkg::PADDLE_START,
  parameter int STEP = breakout_pkg::STEP,
  parameter int TICK_DIV = breakout_pkg::TICK_DIV,
  parameter int DEBOUNCE_CYCLES = breakout_pkg::DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] paddle_x,
  output logic [1:0] dir,
  output logic       move_tick
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] STEP1 = 11'(STEP);
  logic left_lvl, right_lvl, tick_q, wrap;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0] dir_q, dir_d;
  logic [9:0] x_q, x_d, x_dec, x_inc;
  logic [10:0] x_ext, step;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .reset(reset), .btn_i(btn_left), .level_o(left_lvl)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .reset(reset), .btn_i(btn_right), .level_o(right_lvl)
  );
`ifdef PADDLE_ACCEL_EN
  logic [3:0] run_q, run_d;
  logic [1:0] last_q;
  logic moving, hit, same;
  // run length of consecutive same-direction ticks; a fresh direction starts from the base step
  always_comb begin
    same = dir_q == last_q;
    step = (same && run_q >= 4'd8) ? STEP1 << 1 : STEP1;
    moving = tick_q && dir_q != DIR_IDLE;
    hit = (dir_q == DIR_LEFT) ? x_dec == '0 : x_inc == 10'(X_MAX);
    run_d = (dir_q == DIR_IDLE) ? '0 : !moving ? run_q : hit ? '0 : !same ? 4'd1 : (run_q == 4'hf) ? run_q : run_q + 4'd1;
  end
  // run counter and the direction it belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
      last_q <= DIR_IDLE;
    end else begin
      run_q <= run_d;
      last_q <= moving ? dir_q : last_q;
    end
  end
`else
  assign step = STEP1;
`endif
  // tick divider, move decode and clamped next position
  always_comb begin
    wrap = tick_cnt_q == TW'(TICK_DIV - 1);
    tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
    dir_d = (left_lvl && !right_lvl) ? DIR_LEFT : (right_lvl && !left_lvl) ? DIR_RIGHT : DIR_IDLE;
    x_ext = {1'b0, x_q};
    x_dec = (x_ext < step) ? '0 : 10'(x_ext - step);
    x_inc = (x_ext + step > X_MAX) ? 10'(X_MAX) : 10'(x_ext + step);
    x_d = !tick_q ? x_q : (dir_q == DIR_LEFT) ? x_dec : (dir_q == DIR_RIGHT) ? x_inc : x_q;
  end
  // tick, state and position registers; a move uses the state held before this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      tick_q <= 1'b0;
      dir_q <= DIR_IDLE;
      x_q <= 10'(PADDLE_START);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q <= wrap;
      dir_q <= dir_d;
      x_q <= x_d;
    end
  end
  assign paddle_x = x_q;
  assign dir = dir_q;
  assign move_tick = tick_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed checks of paddle_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3, STEP=4
module tb_paddle_ctrl;
  logic clk = 1'b0;
  logic reset, btn_left, btn_right;
  logic [9:0] paddle_x;
  logic [1:0] dir;
  logic move_tick;
  int checks = 0;
  int errors = 0;
  paddle_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .paddle_x(paddle_x), .dir(dir), .move_tick(move_tick)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // advance through n movement edges; each returns on the negedge just after the move
  task automatic tick_move(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (move_tick !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (w == 10) chk("tick_timeout", {31'd0, move_tick}, 32'd1);
      @(negedge clk);
    end
  endtask
  initial begin
    reset = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk("rst_x", paddle_x, 270);
    chk("rst_dir", dir, 0);
    chk("rst_tick", move_tick, 0);
    cyc(3);
    chk("tick_pre", move_tick, 0);
    cyc(1);
    chk("tick_first", move_tick, 1);
    cyc(1);
    chk("tick_pulse", move_tick, 0);
    btn_right = 1'b1;
    cyc(5);
    chk("right_lat5", dir, 0);
    cyc(1);
    chk("right_lat6", dir, 2);
    chk("right_x0", paddle_x, 270);
    tick_move(1);
    chk("right_x1", paddle_x, 274);
    cyc(2);
    chk("right_hold", paddle_x, 274);
    tick_move(1);
    chk("right_x2", paddle_x, 278);
    tick_move(65);
    chk("right_538", paddle_x, 538);
    tick_move(1);
    chk("right_clamp", paddle_x, 540);
    tick_move(1);
    chk("right_stay", paddle_x, 540);
    reset = 1'b1;
    btn_right = 1'b0;
    cyc(1);
    chk("midrst_x", paddle_x, 270);
    chk("midrst_dir", dir, 0);
    chk("midrst_tick", move_tick, 0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    chk("midrst_tick_pre", move_tick, 0);
    cyc(1);
    chk("midrst_tick_first", move_tick, 1);
    btn_left = 1'b1;
    cyc(2);
    btn_left = 1'b0;
    cyc(8);
    chk("glitch_dir", dir, 0);
    chk("glitch_x", paddle_x, 270);
    btn_left = 1'b1;
    btn_right = 1'b1;
    cyc(12);
    chk("both_dir", dir, 0);
    chk("both_x", paddle_x, 270);
    btn_left = 1'b0;
    btn_right = 1'b0;
    cyc(8);
    btn_left = 1'b1;
    cyc(6);
    chk("left_dir", dir, 1);
    tick_move(1);
    chk("left_x1", paddle_x, 266);
    cyc(2);
    btn_left = 1'b0;
    btn_right = 1'b1;
    cyc(1);
    chk("sw_tick_pending", move_tick, 1);
    cyc(1);
    chk("sw_x_a", paddle_x, 262);
    cyc(4);
    chk("sw_old_state", paddle_x, 258);
    chk("sw_dir_new", dir, 2);
    cyc(3);
    chk("sw_between", paddle_x, 258);
    cyc(1);
    chk("sw_new_state", paddle_x, 262);
    btn_right = 1'b0;
    cyc(10);
    chk("rel_x", paddle_x, 266);
    chk("rel_dir", dir, 0);
    btn_left = 1'b1;
    cyc(6);
    chk("left2_dir", dir, 1);
    chk("left2_x", paddle_x, 266);
    tick_move(66);
    chk("left_2", paddle_x, 2);
    tick_move(1);
    chk("left_clamp", paddle_x, 0);
    tick_move(1);
    chk("left_stay", paddle_x, 0);
    btn_left = 1'b0;
`ifdef PADDLE_ACCEL_EN
    cyc(10);
    btn_right = 1'b1;
    cyc(6);
    tick_move(8);
    chk("accel_8", paddle_x, 32);
    tick_move(1);
    chk("accel_9", paddle_x, 40);
    tick_move(1);
    chk("accel_10", paddle_x, 48);
    btn_right = 1'b0;
    cyc(10);
    chk("accel_rel", paddle_x, 56);
    btn_right = 1'b1;
    cyc(6);
    tick_move(1);
    chk("accel_repress", paddle_x, 60);
    btn_right = 1'b0;
`endif
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
